// File: rtl/multiplier_axi4_lite_master.sv
// AXI4-Lite initiator running one multiply job on the multiplier slave:
// writes A, B, START, polls DONE with a bounded retry count, then reads P.
module multiplier_axi4_lite_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h7c800000,
    parameter int unsigned POLL_LIMIT = 64,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    output logic [31:0] res_p,
    output logic [1:0]  res_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [31:0] OFF_A     = 32'h00;
    localparam logic [31:0] OFF_B     = 32'h04;
    localparam logic [31:0] OFF_START = 32'h08;
    localparam logic [31:0] OFF_P     = 32'h0C;
    localparam logic [31:0] OFF_DONE  = 32'h10;

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, WR_START, RD_DONE, GAP, RD_P, RESP
    } state_t;

    state_t      state, state_next;
    logic        started;
    logic [31:0] a_q, b_q;
    logic [31:0] poll_cnt, gap_cnt;
    logic        b_hs, r_hs, poll_last;

    // started marks that the current state's transaction has been issued
    assign b_hs        = started && M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs        = started && M_AXI_RVALID && M_AXI_RREADY;
    assign poll_last   = (poll_cnt + 32'd1) == POLL_LIMIT;
    assign M_AXI_WSTRB = 4'hF;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = WR_A;
            end
            WR_A:     if (b_hs) state_next = (M_AXI_BRESP != 2'b00) ? RESP : WR_B;
            WR_B:     if (b_hs) state_next = (M_AXI_BRESP != 2'b00) ? RESP : WR_START;
            WR_START: if (b_hs) state_next = (M_AXI_BRESP != 2'b00) ? RESP : RD_DONE;
            RD_DONE: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != 2'b00)  state_next = RESP;
                    else if (M_AXI_RDATA[0])   state_next = RD_P;
                    else if (poll_last)        state_next = RESP;
                    else if (POLL_GAP == 0)    state_next = RD_DONE;
                    else                       state_next = GAP;
                end
            end
            GAP:  if ((gap_cnt + 32'd1) == POLL_GAP) state_next = RD_DONE;
            RD_P: if (r_hs) state_next = RESP;
            RESP: begin
                res_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            started       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            res_p         <= '0;
            res_err       <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    started <= 1'b0;
                    if (cmd_valid) begin
                        a_q      <= cmd_a;
                        b_q      <= cmd_b;
                        poll_cnt <= '0;
                        gap_cnt  <= '0;
                    end
                end
                WR_A, WR_B, WR_START: begin
                    if (!started) begin
                        started       <= 1'b1;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_BREADY  <= 1'b1;
                        case (state)
                            WR_A: begin
                                M_AXI_AWADDR <= BASE_ADDR + OFF_A;
                                M_AXI_WDATA  <= a_q;
                            end
                            WR_B: begin
                                M_AXI_AWADDR <= BASE_ADDR + OFF_B;
                                M_AXI_WDATA  <= b_q;
                            end
                            default: begin
                                M_AXI_AWADDR <= BASE_ADDR + OFF_START;
                                M_AXI_WDATA  <= 32'd1;
                            end
                        endcase
                    end else begin
                        // AW and W retire independently; B closes the phase
                        if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                        if (b_hs) begin
                            M_AXI_BREADY <= 1'b0;
                            started      <= 1'b0;
                            if (M_AXI_BRESP != 2'b00) begin
                                res_err <= 2'b01;
                                res_p   <= '0;
                            end
                        end
                    end
                end
                RD_DONE, RD_P: begin
                    if (!started) begin
                        started       <= 1'b1;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b1;
                        M_AXI_ARADDR  <= BASE_ADDR + ((state == RD_P) ? OFF_P : OFF_DONE);
                    end else begin
                        if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
                        if (r_hs) begin
                            M_AXI_RREADY <= 1'b0;
                            started      <= 1'b0;
                            if (M_AXI_RRESP != 2'b00) begin
                                res_err <= 2'b01;
                                res_p   <= '0;
                            end else if (state == RD_P) begin
                                res_err <= 2'b00;
                                res_p   <= M_AXI_RDATA;
                            end else if (!M_AXI_RDATA[0]) begin
                                poll_cnt <= poll_cnt + 32'd1;
                                gap_cnt  <= '0;
                                if (poll_last) begin
                                    res_err <= 2'b10;
                                    res_p   <= '0;
                                end
                            end
                        end
                    end
                end
                GAP: gap_cnt <= gap_cnt + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_axi4_lite_master.sv
// Scoreboard bench for multiplier_axi4_lite_master against a behavioural slave.
module tb_multiplier_axi4_lite_master;
    localparam logic [31:0] BASE = 32'h7c800000;
    localparam int unsigned PLIM = 4;
    localparam int unsigned PGAP = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, res_valid;
    logic [31:0] cmd_a, cmd_b, res_p;
    logic [1:0]  res_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    multiplier_axi4_lite_master #(.BASE_ADDR(BASE), .POLL_LIMIT(PLIM), .POLL_GAP(PGAP)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_p(res_p), .res_err(res_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int unsigned aw_delay = 0, w_delay = 0, done_delay = 10;
    logic        done_stuck = 1'b0, err_en = 1'b0;
    logic [31:0] err_off = '0;

    int unsigned aw_wait, w_wait, start_cyc, last_r_done_cyc;
    logic        aw_got, w_got, started_s, last_done_v, rd_is_done;
    logic [31:0] aw_l, w_l, ra, rb;
    int unsigned wr_cnt = 0, b_cnt = 0, rd_done_cnt = 0, rd_p_cnt = 0, gap_short = 0;
    logic [63:0] act_wr[$];

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign arready = arvalid;

    always @(posedge clk) begin
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 0; w_got <= 0; started_s <= 0;
            bvalid <= 0; bresp <= 0; rvalid <= 0; rresp <= 0; rdata <= 0;
            last_done_v <= 0; rd_is_done <= 0; ra <= 0; rb <= 0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1; aw_l <= awaddr; wr_cnt <= wr_cnt + 1; end
            if (wvalid && wready) begin w_got <= 1; w_l <= wdata; end
            if (aw_got && w_got && !bvalid) begin
                aw_got <= 0; w_got <= 0; bvalid <= 1;
                act_wr.push_back({aw_l, w_l});
                if (err_en && aw_l == BASE + err_off) bresp <= 2'b10;
                else begin
                    bresp <= 2'b00;
                    if (aw_l == BASE) ra <= w_l;
                    else if (aw_l == BASE + 32'h4) rb <= w_l;
                    else if (aw_l == BASE + 32'h8) begin
                        started_s <= 1; start_cyc <= cyc; last_done_v <= 0;
                    end
                end
            end
            if (bvalid && bready) begin bvalid <= 0; b_cnt <= b_cnt + 1; end
            if (arvalid && arready) begin
                rvalid <= 1; rresp <= 2'b00;
                rd_is_done <= (araddr == BASE + 32'h10);
                if (araddr == BASE + 32'h10) begin
                    rd_done_cnt <= rd_done_cnt + 1;
                    rdata <= {31'b0, started_s && !done_stuck && (cyc >= start_cyc + done_delay)};
                    if (last_done_v && (cyc - last_r_done_cyc - 1) < PGAP) gap_short <= gap_short + 1;
                end else if (araddr == BASE + 32'hC) begin
                    rd_p_cnt <= rd_p_cnt + 1;
                    rdata <= ra * rb;
                end else rdata <= '0;
            end
            if (rvalid && rready) begin
                rvalid <= 0;
                if (rd_is_done) begin last_done_v <= 1; last_r_done_cyc <= cyc; end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct { logic [31:0] p; logic [1:0] err; } res_t;
    res_t        exp_res[$];
    logic [63:0] exp_wr[$];
    int unsigned res_cycs[$];
    int unsigned res_seen = 0, viol = 0, split_cnt = 0;
    logic        prev_res_valid = 0, prev_rst = 1;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_wd = '0, p_ara = '0;

    always @(negedge clk) begin
        res_t        e;
        logic [63:0] w;
        if (res_valid) begin
            if (exp_res.size() == 0) begin
                checks++; failures++;
                $display("FAIL res_unexpected actual=p:0x%0h,err:%0d required=none", res_p, res_err);
            end else begin
                e = exp_res.pop_front();
                check("res_p", {32'b0, res_p}, {32'b0, e.p});
                check("res_err", {62'b0, res_err}, {62'b0, e.err});
            end
            check("res_single_cycle", {63'b0, prev_res_valid}, 64'd0);
            res_cycs.push_back(cyc);
            res_seen++;
        end
        prev_res_valid = res_valid;
        while (act_wr.size() > 0) begin
            w = act_wr.pop_front();
            if (exp_wr.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected actual=0x%0h required=none", w);
            end else check("wr_addr_data", w, exp_wr.pop_front());
        end
        if (!areset && !prev_rst) begin
            if (p_awv && !p_awr && !awvalid) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) viol++;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) viol++;
            if ((awvalid || wvalid || bready) && (arvalid || rready)) viol++;
            if (wstrb !== 4'hF) viol++;
            if (!awvalid && wvalid) split_cnt++;
        end
        prev_rst = areset;
        p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready; p_wd = wdata;
        p_arv = arvalid; p_arr = arready; p_ara = araddr;
    end

    // ---------------- stimulus ----------------
    task automatic expect_job(input logic [31:0] a, b, p, input logic [1:0] err, input int nwr);
        res_t r;
        r.p = p; r.err = err;
        exp_res.push_back(r);
        exp_wr.push_back({BASE, a});
        exp_wr.push_back({BASE + 32'h4, b});
        if (nwr == 3) exp_wr.push_back({BASE + 32'h8, 32'd1});
    endtask

    task automatic send(input logic [31:0] a, b, output int unsigned hs_cyc);
        int unsigned n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        hs_cyc = cyc;
        check("cmd_accept", {63'b0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_res(input int unsigned target);
        int unsigned n = 0;
        while (res_seen < target && n < 2000) begin @(posedge clk); n++; end
        check("res_arrival", {63'b0, res_seen >= target}, 64'd1);
    endtask

    initial begin
        int unsigned h1, h2, wr0, b0, d0, p0, s0, n;
        areset = 1; cmd_valid = 0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("rst_valids", {58'b0, awvalid, wvalid, bready, arvalid, rready, res_valid}, 64'd0);
        check("rst_res", {30'b0, res_err, res_p}, 64'd0);
        check("rst_addr_data", {awaddr, wdata | araddr}, 64'd0);
        check("rst_wstrb", {60'b0, wstrb}, 64'hF);
        areset = 0;

        // 1: 15*15
        wr0 = wr_cnt; b0 = b_cnt; d0 = rd_done_cnt; p0 = rd_p_cnt;
        expect_job(15, 15, 225, 2'b00, 3);
        send(15, 15, h1);
        wait_res(1);
        check("t1_writes", 64'(wr_cnt - wr0), 64'd3);
        check("t1_bresps", 64'(b_cnt - b0), 64'd3);
        check("t1_p_reads", 64'(rd_p_cnt - p0), 64'd1);
        check("t1_done_polled", {63'b0, (rd_done_cnt - d0) >= 1}, 64'd1);

        // 2: back-to-back, second accepted the cycle after first RESP
        expect_job(0, 7, 0, 2'b00, 3);
        expect_job(32'hFFFF, 32'hFFFF, 32'hFFFE0001, 2'b00, 3);
        send(0, 7, h1);
        send(32'hFFFF, 32'hFFFF, h2);
        wait_res(3);
        check("t2_accept_after_res", 64'(h2), 64'(res_cycs[1] + 1));

        // 3: AWREADY ahead of WREADY
        w_delay = 3; s0 = split_cnt; wr0 = wr_cnt; b0 = b_cnt;
        expect_job(6, 7, 42, 2'b00, 3);
        send(6, 7, h1);
        wait_res(4);
        w_delay = 0;
        check("t3_aw_dropped_first", {63'b0, (split_cnt - s0) > 0}, 64'd1);
        check("t3_writes", 64'(wr_cnt - wr0), 64'd3);
        check("t3_bresps", 64'(b_cnt - b0), 64'd3);

        // 4: SLVERR on B aborts job
        err_en = 1; err_off = 32'h4; wr0 = wr_cnt; d0 = rd_done_cnt; p0 = rd_p_cnt;
        expect_job(9, 9, 0, 2'b01, 2);
        send(9, 9, h1);
        wait_res(5);
        err_en = 0;
        check("t4_writes", 64'(wr_cnt - wr0), 64'd2);
        check("t4_reads", 64'((rd_done_cnt - d0) + (rd_p_cnt - p0)), 64'd0);

        // 5: DONE never set -> timeout after PLIM polls
        done_stuck = 1; d0 = rd_done_cnt; p0 = rd_p_cnt;
        expect_job(2, 3, 0, 2'b10, 3);
        send(2, 3, h1);
        wait_res(6);
        done_stuck = 0;
        check("t5_done_reads", 64'(rd_done_cnt - d0), 64'(PLIM));
        check("t5_p_reads", 64'(rd_p_cnt - p0), 64'd0);

        // 6: reset while ARVALID high, then a fresh job
        done_delay = 1000;
        exp_wr.push_back({BASE, 32'd4});
        exp_wr.push_back({BASE + 32'h4, 32'd4});
        exp_wr.push_back({BASE + 32'h8, 32'd1});
        send(4, 4, h1);
        n = 0;
        while (!arvalid && n < 200) begin @(negedge clk); n++; end
        check("t6_arvalid_seen", {63'b0, arvalid}, 64'd1);
        areset = 1;
        @(negedge clk);
        check("t6_rst_valids", {58'b0, awvalid, wvalid, bready, arvalid, rready, res_valid}, 64'd0);
        areset = 0;
        @(negedge clk);
        check("t6_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        done_delay = 10;
        expect_job(3, 5, 15, 2'b00, 3);
        send(3, 5, h1);
        wait_res(7);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("protocol_violations", 64'(viol), 64'd0);
        check("poll_gap_short", 64'(gap_short), 64'd0);
        check("pending_results", 64'(exp_res.size()), 64'd0);
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
